pkt_rx_checker: RTL and testbench
=================================

Name: pkt_rx_checker

Overview:
- Receive-side endpoint of the packet stream interface (sop/vld/data/eop) driven by the data generator path.
- Parses the header word, counts payload words, checks framing and length, and reports per-packet status plus running statistics.
- Sits at the ingress of the cache simulation and test fabric. Used as the sink and scoreboard front-end for generated traffic.
- The interface has no backpressure: the checker accepts a word on every cycle.

Parameters:
- DW, 32, data word width; must be >= 17.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- i_sop  input  1  start of packet; qualified by i_vld
- i_vld  input  1  word valid
- i_data  input  DW  data word
- i_eop  input  1  end of packet; qualified by i_vld
- o_hdr_vld  output  1  one-cycle pulse: header captured
- o_da  output  4  destination address from the header
- o_prior  output  3  priority from the header
- o_len  output  10  payload length in words from the header
- o_pkt_done  output  1  one-cycle pulse: packet closed
- o_pkt_ok  output  1  status of the closed packet; valid with o_pkt_done
- o_err_len  output  1  length mismatch; valid with o_pkt_done
- o_err_sop  output  1  packet truncated by a new sop; valid with o_pkt_done
- o_err_orphan  output  1  one-cycle pulse: valid word received outside a packet
- o_pkt_cnt  output  CNT_W  number of packets closed with ok status
- o_err_cnt  output  CNT_W  number of error events

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous and active-low on rst_n. All outputs and state reset to 0; FSM resets to IDLE.
- Qualification: i_sop and i_eop are ignored when i_vld=0. There is no ready signal.
- Header word (the word carrying sop): da=i_data[3:0], prior=i_data[6:4], len=i_data[16:7]. Upper bits are ignored.
- Payload: the words after the header. len counts payload words, 0..1023. Payload is not parsed unless PAYLOAD_CHK_EN is defined.
- Latency: all outputs are registered. Each response appears on the cycle after the edge that sampled the causing word.
- Counter: payload counter is 11 bits and saturates at 2047.
- FSM states: IDLE, PAYLOAD.
- IDLE, vld&sop: capture the header and pulse o_hdr_vld.
  - If eop is also set: close the packet. ok=1 if len==0, else err_len=1. Stay in IDLE.
  - Otherwise: clear the counter and go to PAYLOAD.
- IDLE, vld&!sop: pulse o_err_orphan, increment o_err_cnt, discard the word. This applies regardless of eop.
- PAYLOAD, vld&!sop&!eop: counter increments.
- PAYLOAD, vld&!sop&eop: close the packet with ok=1 if counter+1==len, else err_len=1. Go to IDLE.
- PAYLOAD, vld&sop: close the current packet with err_sop=1, ok=0, err_len=0. In the same cycle, capture the new header and pulse o_hdr_vld, so o_pkt_done and o_hdr_vld assert together.
  - If eop is also set, the new packet is handled as the IDLE sop&eop case, and its close is reported on the following cycle.
  - Otherwise stay in PAYLOAD with the counter cleared.
- Close statistics: each packet close increments exactly one of o_pkt_cnt (ok) or o_err_cnt (error).
- Counter width: both statistics counters wrap modulo 2^CNT_W.
- Output holding: o_da, o_prior and o_len hold until the next header. Status outputs are valid only with o_pkt_done and read 0 otherwise.
- Reset mid-packet: the partial packet is discarded silently, with no done pulse.

Optional Feature:
- Macro: PAYLOAD_CHK_EN.
- Defined:
  - Payload word i (0-based) must equal {da, i[9:0]}, zero-extended to DW.
  - Any mismatch sets a sticky per-packet flag. At close this forces ok=0 and asserts an extra output o_err_data (1 bit, valid with o_pkt_done).
  - Length and sop errors are still reported alongside o_err_data.
- Not defined: the o_err_data port does not exist and payload contents are ignored.

Test Plan:
- Normal packet: header da=5, prior=3, len=4, then 4 payload words with eop on the 4th. Required: o_hdr_vld one cycle after the header with o_da=5, o_prior=3, o_len=4; o_pkt_done with o_pkt_ok=1 one cycle after eop; o_pkt_cnt=1.
- Single-word packets: header with len=0 and sop&eop in one word. Required: o_hdr_vld and o_pkt_done in the same cycle, ok=1. Same with len=2: err_len=1, o_err_cnt=1.
- Short and long packets: len=3 closed after 2 payload words, then len=3 closed after 5 payload words. Required: both report err_len=1, ok=0; o_err_cnt=2.
- Truncation: sop arrives after 1 of 6 payload words, then the new packet (len=1) completes normally. Required: done with err_sop=1 coincides with o_hdr_vld; the second packet reports ok=1.
- Orphans and idle gaps: 3 valid words without sop while IDLE, with i_vld gaps inserted mid-packet. Required: 3 o_err_orphan pulses; gaps do not advance the counter; a later packet reports ok=1.
- Reset and wrap: assert rst_n low mid-packet, check all outputs return to 0 and no done pulse appears. With CNT_W=4, send 17 good packets; required o_pkt_cnt=1.

Source files
------------

// File: rtl/pkt_rx_checker.sv
// Receive-side packet checker: parses headers, counts payload, flags framing and length errors.
// Optional payload content check is enabled by defining PAYLOAD_CHK_EN (adds o_err_data).
module pkt_rx_checker #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_sop,
    input  logic             i_vld,
    input  logic [DW-1:0]    i_data,
    input  logic             i_eop,
    output logic             o_hdr_vld,
    output logic [3:0]       o_da,
    output logic [2:0]       o_prior,
    output logic [9:0]       o_len,
    output logic             o_pkt_done,
    output logic             o_pkt_ok,
    output logic             o_err_len,
    output logic             o_err_sop,
    output logic             o_err_orphan,
    output logic [CNT_W-1:0] o_pkt_cnt,
    output logic [CNT_W-1:0] o_err_cnt
`ifdef PAYLOAD_CHK_EN
    ,
    output logic             o_err_data
`endif
);

    typedef enum logic {IDLE, PAYLOAD} state_t;

    state_t      state;
    logic [10:0] cnt;
    logic        pend;
    logic [3:0]  pend_st;

    // Close status vectors are {data, sop, len, ok}.
    logic        hdr, orphan, cls, new_cls, rep_vld, len_ok, data_now, data_old;
    logic [3:0]  cls_st, new_st, rep_st;
    logic [9:0]  hdr_len;
    logic [11:0] cnt_p1;
    logic [1:0]  err_inc;

    assign hdr     = i_vld & i_sop;
    assign orphan  = i_vld & ~i_sop & (state == IDLE);
    assign hdr_len = i_data[16:7];
    assign cnt_p1  = {1'b0, cnt} + 12'd1;
    assign len_ok  = (cnt_p1 == {2'b00, o_len});

`ifdef PAYLOAD_CHK_EN
    logic          data_err;
    logic          word_bad;
    logic [DW-1:0] exp_word;

    always_comb begin
        exp_word       = '0;
        exp_word[13:0] = {o_da, cnt[9:0]};
    end

    assign word_bad = (state == PAYLOAD) && i_vld && !i_sop && (i_data != exp_word);
    assign data_now = data_err | word_bad;
    assign data_old = data_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_err   <= 1'b0;
            o_err_data <= 1'b0;
        end else begin
            if (hdr)
                data_err <= 1'b0;
            else if (word_bad)
                data_err <= 1'b1;
            o_err_data <= rep_st[3];
        end
    end
`else
    logic          unused_st;
    logic [DW-1:0] unused_data;
    assign data_now    = 1'b0;
    assign data_old    = 1'b0;
    assign unused_st   = rep_st[3];
    assign unused_data = i_data;
`endif

    always_comb begin
        cls     = 1'b0;
        cls_st  = 4'b0000;
        new_cls = 1'b0;
        new_st  = 4'b0000;
        if (hdr && i_eop) begin
            new_cls = 1'b1;
            new_st  = (hdr_len == 10'd0) ? 4'b0001 : 4'b0010;
        end
        if (state == PAYLOAD && i_vld) begin
            if (i_sop) begin
                cls    = 1'b1;
                cls_st = {data_old, 3'b100};
            end else if (i_eop) begin
                cls    = 1'b1;
                cls_st = {data_now, 1'b0, ~len_ok, len_ok & ~data_now};
            end
        end
    end

    // A truncating sop that also carries eop yields two closes in one cycle;
    // the second one is parked and reported on the next cycle.
    always_comb begin
        rep_vld = 1'b0;
        rep_st  = 4'b0000;
        if (pend) begin
            rep_vld = 1'b1;
            rep_st  = pend_st;
        end else if (cls) begin
            rep_vld = 1'b1;
            rep_st  = cls_st;
        end else if (new_cls) begin
            rep_vld = 1'b1;
            rep_st  = new_st;
        end
        err_inc = {1'b0, rep_vld & ~rep_st[0]} + {1'b0, orphan};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            pend         <= 1'b0;
            pend_st      <= '0;
            o_hdr_vld    <= 1'b0;
            o_da         <= '0;
            o_prior      <= '0;
            o_len        <= '0;
            o_pkt_done   <= 1'b0;
            o_pkt_ok     <= 1'b0;
            o_err_len    <= 1'b0;
            o_err_sop    <= 1'b0;
            o_err_orphan <= 1'b0;
            o_pkt_cnt    <= '0;
            o_err_cnt    <= '0;
        end else begin
            pend    <= (pend | cls) & new_cls;
            pend_st <= new_st;
            if (hdr) begin
                state   <= i_eop ? IDLE : PAYLOAD;
                cnt     <= '0;
                o_da    <= i_data[3:0];
                o_prior <= i_data[6:4];
                o_len   <= hdr_len;
            end else if (state == PAYLOAD && i_vld) begin
                if (i_eop)
                    state <= IDLE;
                if (cnt != 11'd2047)
                    cnt <= cnt + 11'd1;
            end
            o_hdr_vld    <= hdr;
            o_pkt_done   <= rep_vld;
            o_pkt_ok     <= rep_st[0];
            o_err_len    <= rep_st[1];
            o_err_sop    <= rep_st[2];
            o_err_orphan <= orphan;
            o_pkt_cnt    <= o_pkt_cnt + CNT_W'(rep_vld & rep_st[0]);
            o_err_cnt    <= o_err_cnt + CNT_W'(err_inc);
        end
    end

endmodule

// File: tb/tb_pkt_rx_checker.sv
// Directed bench for pkt_rx_checker: per-cycle vector table plus reset and counter-wrap sequences.
module tb_pkt_rx_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_sop = 1'b0, i_vld = 1'b0, i_eop = 1'b0;
    logic [31:0] i_data = '0;
    logic        o_hdr_vld, o_pkt_done, o_pkt_ok, o_err_len, o_err_sop, o_err_orphan;
    logic [3:0]  o_da;
    logic [2:0]  o_prior;
    logic [9:0]  o_len;
    logic [3:0]  o_pkt_cnt, o_err_cnt;
    logic [30:0] act;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pkt_rx_checker #(.DW(32), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .i_sop(i_sop), .i_vld(i_vld), .i_data(i_data), .i_eop(i_eop),
        .o_hdr_vld(o_hdr_vld), .o_da(o_da), .o_prior(o_prior), .o_len(o_len),
        .o_pkt_done(o_pkt_done), .o_pkt_ok(o_pkt_ok), .o_err_len(o_err_len), .o_err_sop(o_err_sop),
        .o_err_orphan(o_err_orphan), .o_pkt_cnt(o_pkt_cnt), .o_err_cnt(o_err_cnt)
`ifdef PAYLOAD_CHK_EN
        , .o_err_data()
`endif
    );

    assign act = {o_hdr_vld, o_da, o_prior, o_len, o_pkt_done, o_pkt_ok, o_err_len,
                  o_err_sop, o_err_orphan, o_pkt_cnt, o_err_cnt};

    typedef struct {
        logic        vld, sop, eop;
        logic [31:0] data;
        logic [30:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic logic [31:0] hw(input logic [3:0] da, input logic [2:0] pr, input logic [9:0] ln);
        return {15'b0, ln, pr, da};
    endfunction

    function automatic logic [31:0] pw(input logic [3:0] da, input logic [9:0] idx);
        return {18'b0, da, idx};
    endfunction

    // Expected fields: hdr_vld, da, prior, len, done, ok, err_len, err_sop, orphan, pkt_cnt, err_cnt
    function automatic vec_t mk(input logic v, input logic s, input logic e, input logic [31:0] d,
                                input logic hv, input logic [3:0] da, input logic [2:0] pr,
                                input logic [9:0] ln, input logic dn, input logic ok,
                                input logic el, input logic es, input logic orp,
                                input logic [3:0] pc, input logic [3:0] ec);
        vec_t r;
        r.vld = v; r.sop = s; r.eop = e; r.data = d;
        r.exp = {hv, da, pr, ln, dn, ok, el, es, orp, pc, ec};
        return r;
    endfunction

    task automatic drive(input logic v, input logic s, input logic e, input logic [31:0] d);
        i_vld = v; i_sop = s; i_eop = e; i_data = d;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [30:0] got, input logic [30:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, got, req);
        end else begin
            $display("ok   %s value=%h", name, got);
        end
    endtask

    initial begin
        // Normal packet
        tv.push_back(mk(0,0,0,32'h0,        0,0,0,0, 0,0,0,0,0, 0,0));
        tv.push_back(mk(1,1,0,hw(5,3,4),    1,5,3,4, 0,0,0,0,0, 0,0));
        tv.push_back(mk(1,0,0,pw(5,0),      0,5,3,4, 0,0,0,0,0, 0,0));
        tv.push_back(mk(1,0,0,pw(5,1),      0,5,3,4, 0,0,0,0,0, 0,0));
        tv.push_back(mk(1,0,0,pw(5,2),      0,5,3,4, 0,0,0,0,0, 0,0));
        tv.push_back(mk(1,0,1,pw(5,3),      0,5,3,4, 1,1,0,0,0, 1,0));
        tv.push_back(mk(0,0,0,32'h0,        0,5,3,4, 0,0,0,0,0, 1,0));
        // Single-word packets
        tv.push_back(mk(1,1,1,hw(1,2,0),    1,1,2,0, 1,1,0,0,0, 2,0));
        tv.push_back(mk(1,1,1,hw(2,0,2),    1,2,0,2, 1,0,1,0,0, 2,1));
        // Short then long
        tv.push_back(mk(1,1,0,hw(3,1,3),    1,3,1,3, 0,0,0,0,0, 2,1));
        tv.push_back(mk(1,0,0,pw(3,0),      0,3,1,3, 0,0,0,0,0, 2,1));
        tv.push_back(mk(1,0,1,pw(3,1),      0,3,1,3, 1,0,1,0,0, 2,2));
        tv.push_back(mk(1,1,0,hw(3,1,3),    1,3,1,3, 0,0,0,0,0, 2,2));
        for (int i = 0; i < 4; i++)
            tv.push_back(mk(1,0,0,pw(3,10'(i)), 0,3,1,3, 0,0,0,0,0, 2,2));
        tv.push_back(mk(1,0,1,pw(3,4),      0,3,1,3, 1,0,1,0,0, 2,3));
        // Truncation by a new sop
        tv.push_back(mk(1,1,0,hw(4,0,6),    1,4,0,6, 0,0,0,0,0, 2,3));
        tv.push_back(mk(1,0,0,pw(4,0),      0,4,0,6, 0,0,0,0,0, 2,3));
        tv.push_back(mk(1,1,0,hw(6,5,1),    1,6,5,1, 1,0,0,1,0, 2,4));
        tv.push_back(mk(1,0,1,pw(6,0),      0,6,5,1, 1,1,0,0,0, 3,4));
        // Orphans and vld gaps
        tv.push_back(mk(1,0,0,32'h1234,     0,6,5,1, 0,0,0,0,1, 3,5));
        tv.push_back(mk(0,0,0,32'h0,        0,6,5,1, 0,0,0,0,0, 3,5));
        tv.push_back(mk(1,0,1,32'h5678,     0,6,5,1, 0,0,0,0,1, 3,6));
        tv.push_back(mk(1,0,0,32'h9abc,     0,6,5,1, 0,0,0,0,1, 3,7));
        tv.push_back(mk(1,1,0,hw(7,7,3),    1,7,7,3, 0,0,0,0,0, 3,7));
        tv.push_back(mk(1,0,0,pw(7,0),      0,7,7,3, 0,0,0,0,0, 3,7));
        tv.push_back(mk(0,1,1,32'hffff_ffff,0,7,7,3, 0,0,0,0,0, 3,7));
        tv.push_back(mk(1,0,0,pw(7,1),      0,7,7,3, 0,0,0,0,0, 3,7));
        tv.push_back(mk(0,0,1,32'h0,        0,7,7,3, 0,0,0,0,0, 3,7));
        tv.push_back(mk(1,0,1,pw(7,2),      0,7,7,3, 1,1,0,0,0, 4,7));
        // Truncating sop that also carries eop: second close one cycle later
        tv.push_back(mk(1,1,0,hw(1,0,2),    1,1,0,2, 0,0,0,0,0, 4,7));
        tv.push_back(mk(1,0,0,pw(1,0),      0,1,0,2, 0,0,0,0,0, 4,7));
        tv.push_back(mk(1,1,1,hw(2,1,0),    1,2,1,0, 1,0,0,1,0, 4,8));
        tv.push_back(mk(0,0,0,32'h0,        0,2,1,0, 1,1,0,0,0, 5,8));
        tv.push_back(mk(0,0,0,32'h0,        0,2,1,0, 0,0,0,0,0, 5,8));
        tv.push_back(mk(1,1,1,hw(3,0,0),    1,3,0,0, 1,1,0,0,0, 6,8));

        repeat (3) @(negedge clk);
        check("reset_state", act, 31'h0);
        rst_n = 1'b1;
        @(negedge clk);

        foreach (tv[k]) begin
            drive(tv[k].vld, tv[k].sop, tv[k].eop, tv[k].data);
            check($sformatf("vec%0d", k), act, tv[k].exp);
        end

        // Reset mid-packet: partial packet is dropped without a done pulse
        drive(1, 1, 0, hw(5, 0, 3));
        drive(1, 0, 0, pw(5, 0));
        #2 rst_n = 1'b0;
        #1 check("async_reset_clears", act, 31'h0);
        i_vld = 1'b0; i_sop = 1'b0; i_eop = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 32'h0);
            check($sformatf("post_reset_idle%0d", i), act, 31'h0);
        end
        drive(1, 0, 1, pw(5, 1));
        check("post_reset_eop_orphan", act, {1'b0, 4'd0, 3'd0, 10'd0, 5'b00001, 4'd0, 4'd1});

        // Statistics counter wrap with a 4-bit counter
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            drive(1, 1, 1, hw(0, 0, 0));
            if (i == 16)
                check("wrap_at_16", act, {1'b1, 4'd0, 3'd0, 10'd0, 5'b11000, 4'd0, 4'd0});
        end
        check("wrap_at_17", act, {1'b1, 4'd0, 3'd0, 10'd0, 5'b11000, 4'd1, 4'd0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
